// File: rtl/cs_meas_ctrl_pkg.sv
// rtl/cs_meas_ctrl_pkg.sv - shared types and PRBS11 constants for the measurement controller
package cs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } cs_state_t;

  localparam int PRBS11_W = 11;
  localparam logic [PRBS11_W-1:0] PRBS11_SEED = 11'h000;
  localparam int PRBS11_TAP_A = 0;
  localparam int PRBS11_TAP_B = 2;

  // chip=1 adds the sample, chip=0 subtracts it
  localparam logic CHIP_ADD = 1'b1;
  localparam logic CHIP_SUB = 1'b0;

endpackage

// File: rtl/cs_meas_ctrl_if.sv
// rtl/cs_meas_ctrl_if.sv - sample input stream and measurement output stream
interface cs_meas_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 21,
  parameter int IDX_W  = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/cs_meas_ctrl_lfsr.sv
// rtl/cs_meas_ctrl_lfsr.sv - PRBS11 chipping sequence generator
// Chip is the MSB of the current state; load wins over en.
module prbs11_lfsr
  import cs_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                en,
  output logic                chip,
  output logic [PRBS11_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= PRBS11_SEED;
    end else if (load) begin
      state <= PRBS11_SEED;
    end else if (en) begin
      state <= {~(state[PRBS11_TAP_A] ^ state[PRBS11_TAP_B]), state[PRBS11_W-1:1]};
    end
  end

  assign chip = state[PRBS11_W-1];

endmodule

// File: rtl/cs_meas_ctrl.sv
// rtl/cs_meas_ctrl.sv - integrate-and-dump compressed-sensing measurement controller
// Accumulates N_SAMPLES chip-modulated samples per measurement, N_MEAS per frame.
module cs_meas_ctrl
  import cs_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int N_MEAS    = 8,
  parameter int DATA_W    = 12,
  parameter int ACC_W     = DATA_W + $clog2(N_SAMPLES) + 1,
  localparam int IDX_W    = (N_MEAS > 1) ? $clog2(N_MEAS) : 1,
  localparam int CNT_W    = $clog2(N_SAMPLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic frame_done,
  cs_meas_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MEAS - 1);

  cs_state_t               state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic                    busy_q;
  logic                    frame_done_q;

  logic                    chip;
  logic [PRBS11_W-1:0]     unused_lfsr_state;
  logic                    sample_hs;
  logic                    lfsr_load;
  logic signed [ACC_W-1:0] sample_ext;

  assign sample_hs  = bus.in_valid & in_ready_q;
  assign lfsr_load  = (state_q == IDLE) & start & ~abort;
  assign sample_ext = {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};

  prbs11_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .en    (sample_hs),
    .chip  (chip),
    .state (unused_lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (abort) begin
        // abort discards the partial measurement without emitting anything
        state_q     <= IDLE;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= ACCUM;
              acc_q      <= '0;
              cnt_q      <= '0;
              idx_q      <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          ACCUM: begin
            if (sample_hs) begin
              acc_q <= (chip == CHIP_ADD) ? acc_q + sample_ext : acc_q - sample_ext;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_LAST) begin
                state_q     <= DUMP;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_last_q  <= (idx_q == IDX_LAST);
              end
            end
          end
          DUMP: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (out_last_q) begin
                state_q      <= IDLE;
                busy_q       <= 1'b0;
                frame_done_q <= 1'b1;
              end else begin
                state_q    <= ACCUM;
                acc_q      <= '0;
                cnt_q      <= '0;
                idx_q      <= idx_q + IDX_W'(1);
                in_ready_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

// File: doc/cs_meas_ctrl.md
# cs_meas_ctrl

Integrate-and-dump measurement controller for the random-demodulator compressed-sensing front end. It drives a PRBS11 chipping sequence, multiplies each incoming ADC sample by ±1 per chip, and accumulates `N_SAMPLES` products into one measurement. It emits `N_MEAS` measurements per frame over a valid/ready stream. The block sits between the sample source and the reconstruction/storage stage, and it owns the sequencing of the PRBS generator.

## Interface
- `N_SAMPLES`, default 256: samples integrated per measurement; power of two, ≥2.
- `N_MEAS`, default 8: measurements per frame; ≥1.
- `DATA_W`, default 12: signed sample width.
- `ACC_W`, default `DATA_W + $clog2(N_SAMPLES) + 1`: signed accumulator and output width.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle frame request.
- `abort` in 1: one-cycle frame cancel.
- `busy` out 1: high whenever not IDLE.
- `in_valid` in 1, `in_ready` out 1, `in_data` in `DATA_W` (signed): sample stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `ACC_W` (signed): measurement stream.
- `out_idx` out `$clog2(N_MEAS)` (min 1): measurement index within the frame.
- `out_last` out 1: high with the frame's final measurement.
- `frame_done` out 1: one-cycle pulse when the frame completes.

## Operation
- States:
  - IDLE, ACCUM, DUMP.
  - All outputs are 0 on reset, and the state is IDLE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 → ACCUM. This also loads LFSR = 11'h000, clears the accumulator, clears the sample count, and sets `out_idx`=0.
- ACCUM:
  - `in_ready`=1.
  - On each handshake (`in_valid & in_ready`), the accumulator adds the sign-extended `in_data` if chip=1 and subtracts it if chip=0. The LFSR steps and the sample count increments.
  - Without a handshake, nothing changes.
- Handshake with count = `N_SAMPLES-1` → DUMP.
- DUMP:
  - `in_ready`=0, `out_valid`=1.
  - `out_data` = the accumulator, held stable until `out_ready`.
  - `out_last` = (`out_idx` == `N_MEAS-1`).
  - On `out_ready`, if not last: → ACCUM, clear the accumulator and count, increment `out_idx`.
  - On `out_ready`, if last: → IDLE and pulse `frame_done`.
- The LFSR is not reloaded between the measurements of a frame. The chip sequence runs continuously across the whole frame.
- LFSR, 11 bits, stepping rule:
  - chip = s[10] of the current state.
  - Next state: s[9:0] ← s[10:1], s[10] ← ~(s[0]^s[2]).
  - From seed 0 the chips are 0,1,1,1,1,1,1,1,1,1,0,…
- Arithmetic:
  - Full precision, and `ACC_W` guarantees no overflow.
  - Negating −2^(DATA_W−1) is exact after sign extension.
- `start` outside IDLE is ignored.
- `abort` in any state:
  - → IDLE on the next cycle.
  - `out_valid`, `in_ready` and `busy` drop.
  - No `frame_done`.
  - The accumulator and `out_idx` are not emitted.
- `abort` and `start` in the same cycle: `abort` wins, and the block stays or returns to IDLE.
- `reset` low mid-frame: identical to reset-from-power-up; no partial output.

## Timing
- A sample handshake on cycle t takes effect in the accumulator at t+1.
- The last sample handshake at t gives `out_valid`=1 at t+1.
- With `out_ready` held high, `out_valid` is high for exactly one cycle. `in_ready` returns at t+2 (one bubble per measurement).
- `frame_done` is asserted in the cycle after the last output handshake, coincident with `busy`=0.
- `busy` rises the cycle after `start` is accepted.
- `in_ready` and `out_valid` are registered (state-decoded) and never combinationally depend on `in_valid` or `out_ready`.

## Structure
- Package `cs_pkg`:
  - state enum `cs_state_t` (IDLE/ACCUM/DUMP);
  - `PRBS11_W`=11;
  - `PRBS11_SEED`=11'h000;
  - the tap positions (0, 2);
  - chip polarity constants.
- Sub-module `prbs11_lfsr`: inputs `clk`, `reset`, `load`, `en`; outputs `chip` and `state[10:0]`. It implements the stepping rule above and is instantiated once.
- The controller FSM, counter, accumulator and output register live in `cs_meas_ctrl`.

## Test plan
- `N_SAMPLES`=4, `N_MEAS`=1, `in_data`=+1 continuous, `out_ready`=1 → `out_data`=2 (chips 0,1,1,1), `out_last`=1, `frame_done` one cycle later.
- `N_SAMPLES`=4, `in_data`=−2048 (`DATA_W`=12) all samples → `out_data` = +2048−2048−2048−2048 = −4096, with no overflow.
- `N_MEAS`=3, `in_valid` toggled randomly, `out_ready` held low 5 cycles on each output:
  - `out_data` stable while stalled;
  - `in_ready`=0 throughout DUMP;
  - `out_idx` 0,1,2;
  - chips continue across measurements, matching the reference LFSR model.
- `abort` pulsed mid-ACCUM of measurement 1 → IDLE next cycle, no `out_valid`, no `frame_done`. A following `start` restarts with seed 0 and `out_idx`=0.
- `start` during ACCUM is ignored; `start`+`abort` in the same IDLE cycle → stays IDLE with `busy`=0.
- `reset` low for 1 cycle during DUMP with `out_valid`=1 → all outputs 0 next cycle and the state is IDLE.
